// File: rtl/branch_redirect.sv
// Branch mispredict redirect controller: flush pulse, then held fetch redirect, plus optional
// return-address stack enabled by defining BRANCH_REDIRECT_RAS_EN.
package core_pkg;
  localparam int unsigned XLEN = 32;
endpackage

module branch_redirect #(
  parameter int unsigned XLEN      = core_pkg::XLEN,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            br_valid,
  input  logic            br_mispredict,
  input  logic [XLEN-1:0] br_target_pc,
  input  logic [5:0]      br_rob_tag,
  input  logic            br_is_call,
  input  logic            br_is_return,
  input  logic [XLEN-1:0] br_return_addr,
  input  logic [5:0]      rob_head,
  output logic            flush_valid,
  output logic [5:0]      flush_rob_tag,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            busy,
  output logic            ras_valid,
  output logic [XLEN-1:0] ras_top
);

  localparam int unsigned TAG_W = 6;

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_e;

  state_e            state_q, state_d;
  logic [TAG_W-1:0]  pend_tag_q, pend_tag_d;
  logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
  logic              flush_valid_q, flush_valid_d;
  logic [TAG_W-1:0]  flush_tag_q, flush_tag_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              busy_q, busy_d;

  logic              mispredict_c;
  logic              older_c;
  logic [TAG_W-1:0]  new_age_c;
  logic [TAG_W-1:0]  pend_age_c;

  // Age relative to the ROB head; wrapping subtraction keeps ordering across tag rollover.
  assign mispredict_c = br_valid & br_mispredict;
  assign new_age_c    = br_rob_tag - rob_head;
  assign pend_age_c   = pend_tag_q - rob_head;
  assign older_c      = new_age_c < pend_age_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      pend_tag_q       <= '0;
      pend_pc_q        <= '0;
      flush_valid_q    <= 1'b0;
      flush_tag_q      <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      pend_tag_q       <= pend_tag_d;
      pend_pc_q        <= pend_pc_d;
      flush_valid_q    <= flush_valid_d;
      flush_tag_q      <= flush_tag_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      busy_q           <= busy_d;
    end
  end

  // Next state; an older mispredict always restarts the flush, even over a redirect handshake.
  always_comb begin
    state_d    = state_q;
    pend_tag_d = pend_tag_q;
    pend_pc_d  = pend_pc_q;
    case (state_q)
      IDLE: begin
        if (mispredict_c) begin
          pend_tag_d = br_rob_tag;
          pend_pc_d  = br_target_pc;
          state_d    = FLUSH;
        end
      end
      FLUSH: begin
        if (mispredict_c && older_c) begin
          pend_tag_d = br_rob_tag;
          pend_pc_d  = br_target_pc;
          state_d    = FLUSH;
        end else begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        if (mispredict_c && older_c) begin
          pend_tag_d = br_rob_tag;
          pend_pc_d  = br_target_pc;
          state_d    = FLUSH;
        end else if (redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    flush_valid_d    = (state_d == FLUSH);
    flush_tag_d      = (state_d == FLUSH) ? pend_tag_d : '0;
    redirect_valid_d = (state_d == REDIRECT);
    redirect_pc_d    = (state_d == REDIRECT) ? pend_pc_d : '0;
    busy_d           = (state_d != IDLE);
  end

  assign flush_valid    = flush_valid_q;
  assign flush_rob_tag  = flush_tag_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign busy           = busy_q;

`ifdef BRANCH_REDIRECT_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  ras_mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
  logic [XLEN-1:0]  ras_top_q, ras_top_d;
  logic             ras_valid_q, ras_valid_d;
  logic             push_c, pop_c;

  assign push_c = br_valid & br_is_call;
  assign pop_c  = br_valid & br_is_return & ~br_is_call & (ras_cnt_q != '0);

  // Pointer is the next write slot; a full stack overwrites its oldest entry.
  always_comb begin
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    ras_top_d = ras_top_q;
    if (push_c) begin
      ras_ptr_d = ras_ptr_q + PTR_W'(1);
      if (ras_cnt_q != CNT_W'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + CNT_W'(1);
      ras_top_d = br_return_addr;
    end else if (pop_c) begin
      ras_ptr_d = ras_ptr_q - PTR_W'(1);
      ras_cnt_d = ras_cnt_q - CNT_W'(1);
      ras_top_d = (ras_cnt_q == CNT_W'(1)) ? '0 : ras_mem_q[ras_ptr_q - PTR_W'(2)];
    end
    ras_valid_d = (ras_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr_q   <= '0;
      ras_cnt_q   <= '0;
      ras_top_q   <= '0;
      ras_valid_q <= 1'b0;
    end else begin
      ras_ptr_q   <= ras_ptr_d;
      ras_cnt_q   <= ras_cnt_d;
      ras_top_q   <= ras_top_d;
      ras_valid_q <= ras_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_c) ras_mem_q[ras_ptr_q] <= br_return_addr;
  end

  assign ras_valid = ras_valid_q;
  assign ras_top   = ras_top_q;
`else
  logic unused_ras_c;
  assign unused_ras_c = ^{br_is_call, br_is_return, br_return_addr};
  assign ras_valid    = 1'b0;
  assign ras_top      = '0;
`endif

endmodule
